// File: rtl/jtkicker_sndfifo_if.sv
// jtkicker_sndfifo_if: main/sound command channel signals between CPU decode and the FIFO
interface jtkicker_sndfifo_if #(
  parameter int DW = 8,
  parameter int AW = 2
);
  logic          wr;
  logic          rd;
  logic          irq_ack;
  logic          ovf_clr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          irqn;
  logic          empty;
  logic          full;
  logic          ovf;
  logic [AW:0]   level;
  logic [7:0]    st_dout;
  modport master (
    output wr, rd, irq_ack, ovf_clr, din,
    input  dout, irqn, empty, full, ovf, level, st_dout
  );
  modport slave (
    input  wr, rd, irq_ack, ovf_clr, din,
    output dout, irqn, empty, full, ovf, level, st_dout
  );
endinterface

// File: rtl/jtkicker_sndfifo.sv
// jtkicker_sndfifo: main-to-sound command FIFO with selectable sound-CPU interrupt modes
module jtkicker_sndfifo #(
  parameter int DW        = 8,
  parameter int AW        = 2,
  parameter int IRQ_MODE  = 0,
  parameter int IRQ_LEN   = 16,
  parameter int OVERWRITE = 0
) (
  input logic               clk,
  input logic               rst,
  jtkicker_sndfifo_if.slave bus
);
  localparam int LW = AW + 1;
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic [7:0]    cnt;
  logic          ovf, pending, empty, full, push, pop, ovr;
  always_comb begin
    empty = level == '0;
    full  = level[AW];
    push  = bus.wr & (!full | bus.rd);
    pop   = bus.rd & !empty;
    ovr   = bus.wr & full & !bus.rd;
  end
  // a push into a full FIFO with a pop in the same cycle is a normal push
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.din;
    else if (ovr && OVERWRITE != 0) mem[wr_ptr - AW'(1)] <= bus.din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      pending <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push);
      rd_ptr  <= rd_ptr + AW'(pop);
      level   <= level + LW'(push) - LW'(pop);
      ovf     <= ovr | (ovf & !bus.ovf_clr);
      cnt     <= (push | (ovr && OVERWRITE != 0)) ? 8'(IRQ_LEN) : cnt - 8'(cnt != '0);
      pending <= bus.wr | (pending & !bus.irq_ack);
    end
  assign bus.dout    = empty ? '0 : mem[rd_ptr];
  assign bus.irqn    = IRQ_MODE == 0 ? empty : IRQ_MODE == 1 ? cnt == '0 : !pending;
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.level   = level;
  assign bus.ovf     = ovf;
  assign bus.st_dout = {ovf, full, empty, bus.irqn, 4'(level)};
endmodule

// File: tb/tb_jtkicker_sndfifo.sv
// tb_jtkicker_sndfifo: three FIFO configurations on shared random/directed stimulus vs a queue model
module tb_jtkicker_sndfifo;
  typedef struct {
    string n;
    int    d;
    int    f;
    int    a;
    int    v;
  } exp_t;
  logic       clk = 0, rst = 1, wr = 0, rd = 0, ack = 0, clr = 0;
  logic [7:0] din = 0;
  bit         chk_en = 0;
  int         tests = 0, fails = 0, lowcnt;
  logic [2:0] lv [3];
  logic       em [3], fu [3], ov [3], iq [3];
  logic [7:0] dd [3], st [3];
  logic [7:0] mq [3][$];
  bit         movf [3], mpend [3];
  int         mcnt [3];
  exp_t       dq [$];
  exp_t       e;
  int         s0 [4] = '{1, 2, 3, 4};
  int         s1 [4] = '{1, 2, 3, 5};

  always #5 clk = ~clk;

  jtkicker_sndfifo_if #(.DW(8), .AW(2)) b0 ();
  jtkicker_sndfifo_if #(.DW(8), .AW(2)) b1 ();
  jtkicker_sndfifo_if #(.DW(8), .AW(2)) b2 ();
  assign {b0.wr, b0.rd, b0.irq_ack, b0.ovf_clr, b0.din} = {wr, rd, ack, clr, din};
  assign {b1.wr, b1.rd, b1.irq_ack, b1.ovf_clr, b1.din} = {wr, rd, ack, clr, din};
  assign {b2.wr, b2.rd, b2.irq_ack, b2.ovf_clr, b2.din} = {wr, rd, ack, clr, din};
  assign {lv[0], em[0], fu[0], ov[0], iq[0], dd[0], st[0]} = {b0.level, b0.empty, b0.full, b0.ovf, b0.irqn, b0.dout, b0.st_dout};
  assign {lv[1], em[1], fu[1], ov[1], iq[1], dd[1], st[1]} = {b1.level, b1.empty, b1.full, b1.ovf, b1.irqn, b1.dout, b1.st_dout};
  assign {lv[2], em[2], fu[2], ov[2], iq[2], dd[2], st[2]} = {b2.level, b2.empty, b2.full, b2.ovf, b2.irqn, b2.dout, b2.st_dout};

  jtkicker_sndfifo #(.DW(8), .AW(2), .IRQ_MODE(0), .IRQ_LEN(16), .OVERWRITE(0)) d0 (.clk(clk), .rst(rst), .bus(b0));
  jtkicker_sndfifo #(.DW(8), .AW(2), .IRQ_MODE(1), .IRQ_LEN(16), .OVERWRITE(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  jtkicker_sndfifo #(.DW(8), .AW(2), .IRQ_MODE(2), .IRQ_LEN(16), .OVERWRITE(0)) d2 (.clk(clk), .rst(rst), .bus(b2));

  // reference: dut0 mode 0, dut1 mode 1 with overwrite, dut2 mode 2
  task automatic model(bit w, logic [7:0] d, bit r, bit a, bit c, bit rs);
    for (int i = 0; i < 3; i++) begin
      bit f, em_, acc, ovr;
      if (rs) begin
        mq[i].delete();
        movf[i] = 0;
        mcnt[i] = 0;
        mpend[i] = 0;
        continue;
      end
      em_ = mq[i].size() == 0;
      f   = mq[i].size() == 4;
      acc = w && (!f || r);
      ovr = w && f && !r;
      if (r && !em_) void'(mq[i].pop_front());
      if (acc) mq[i].push_back(d);
      else if (ovr && i == 1) mq[i][mq[i].size() - 1] = d;
      movf[i] = ovr || (movf[i] && !c);
      if (acc || (ovr && i == 1)) mcnt[i] = 16;
      else if (mcnt[i] > 0) mcnt[i]--;
      if (w) mpend[i] = 1;
      else if (a) mpend[i] = 0;
    end
  endtask

  task automatic cyc(bit w, logic [7:0] d = 0, bit r = 0, bit a = 0, bit c = 0, bit rs = 0);
    @(negedge clk);
    #1;
    wr = w; din = d; rd = r; ack = a; clr = c; rst = rs;
    model(w, d, r, a, c, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic ex(string nm, int d, int f, int v);
    dq.push_back('{nm, d, f, 0, v});
  endtask

  task automatic exa(string nm, int a, int v);
    dq.push_back('{nm, 1, -1, a, v});
  endtask

  task automatic chk(string nm, int d, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, act, exp);
    end
  endtask

  function automatic int get(int d, int f);
    case (f)
      0: return int'(lv[d]);
      1: return int'(em[d]);
      2: return int'(fu[d]);
      3: return int'(ov[d]);
      4: return int'(iq[d]);
      default: return int'(dd[d]);
    endcase
  endfunction

  always @(negedge clk) if (chk_en) begin
    for (int i = 0; i < 3; i++) begin
      int n;
      bit irq;
      n   = mq[i].size();
      irq = i == 0 ? n == 0 : i == 1 ? mcnt[i] == 0 : !mpend[i];
      chk("level", i, int'(lv[i]), n);
      chk("empty", i, int'(em[i]), int'(n == 0));
      chk("full", i, int'(fu[i]), int'(n == 4));
      chk("ovf", i, int'(ov[i]), int'(movf[i]));
      chk("irqn", i, int'(iq[i]), int'(irq));
      chk("dout", i, int'(dd[i]), n > 0 ? int'(mq[i][0]) : 0);
      chk("st_dout", i, int'(st[i]), int'({movf[i], n == 4, n == 0, irq, 4'(n)}));
    end
    while (dq.size() > 0) begin
      e = dq.pop_front();
      chk(e.n, e.d, e.f >= 0 ? get(e.d, e.f) : e.a, e.v);
    end
  end

  initial begin
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk_en = 1;
    ex("rst_level", 0, 0, 0); ex("rst_empty", 0, 1, 1); ex("rst_irqn", 0, 4, 1); ex("rst_dout", 0, 5, 0);
    cyc(1, 8'h12); cyc(1, 8'h34); cyc(1, 8'h56);
    ex("lvl3", 0, 0, 3); ex("head12", 0, 5, 'h12); ex("push_irqn", 0, 4, 0);
    cyc(0, 0, 1); ex("pop34", 0, 5, 'h34);
    cyc(0, 0, 1); ex("pop56", 0, 5, 'h56);
    cyc(0, 0, 1); ex("pop_zero", 0, 5, 0); ex("pop_empty", 0, 1, 1); ex("pop_irqn", 0, 4, 1);
    for (int k = 1; k <= 5; k++) cyc(1, 8'(k));
    ex("ovf_full", 0, 2, 1); ex("ovf_set", 0, 3, 1); ex("ovw_set", 1, 3, 1);
    for (int k = 0; k < 4; k++) begin
      ex("keep_rd", 0, 5, s0[k]); ex("ovw_rd", 1, 5, s1[k]);
      cyc(0, 0, 1);
    end
    ex("drain_empty", 1, 1, 1);
    cyc(0, 0, 0, 0, 1); ex("ovf_clr", 0, 3, 0);
    for (int k = 0; k < 4; k++) cyc(1, 8'('hA0 + k));
    cyc(1, 8'hA4, 1); ex("wrrd_full_lvl", 0, 0, 4); ex("wrrd_full_ovf", 0, 3, 0);
    cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1); ex("wrrd_last", 0, 5, 'hA4);
    cyc(0, 0, 1); ex("wrrd_drained", 0, 1, 1);
    cyc(1, 8'h77, 1); ex("wrrd_empty_lvl", 0, 0, 1); ex("wrrd_empty_dout", 0, 5, 'h77);
    cyc(0, 0, 1);
    repeat (20) cyc(0);
    ex("pulse_idle", 1, 4, 1);
    lowcnt = 0;
    cyc(1, 8'h11); lowcnt += int'(!b1.irqn);
    repeat (9) begin cyc(0); lowcnt += int'(!b1.irqn); end
    cyc(1, 8'h22); lowcnt += int'(!b1.irqn);
    repeat (40) begin cyc(0); lowcnt += int'(!b1.irqn); end
    exa("pulse_len", lowcnt, 26);
    cyc(0, 0, 1); cyc(0, 0, 1);
    cyc(0, 0, 0, 1); ex("m2_ack_idle", 2, 4, 1);
    cyc(1, 8'h33); ex("m2_push", 2, 4, 0);
    cyc(1, 8'h44, 0, 1); ex("m2_push_ack", 2, 4, 0);
    cyc(0, 0, 0, 1); ex("m2_ack", 2, 4, 1);
    cyc(0, 0, 1); cyc(0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(1, 8'('hB0 + k));
    cyc(0, 0, 1); ex("pre_rst_lvl", 0, 0, 3); ex("pre_rst_ovf", 0, 3, 1);
    cyc(1, 8'hC0, 1, 1, 0, 1);
    ex("mid_rst_lvl", 0, 0, 0); ex("mid_rst_empty", 0, 1, 1); ex("mid_rst_ovf", 0, 3, 0);
    ex("mid_rst_irqn0", 0, 4, 1); ex("mid_rst_dout", 0, 5, 0);
    ex("mid_rst_irqn1", 1, 4, 1); ex("mid_rst_irqn2", 2, 4, 1);
    for (int k = 0; k < 3000; k++)
      cyc(($urandom % 10) < (k < 1500 ? 6 : 4), 8'($urandom), ($urandom % 10) < 5,
          ($urandom % 10) == 0, ($urandom % 20) == 0, ($urandom % 150) == 0);
    cyc(0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
